// File: rtl/mac_kbd_pkg.sv
// Shared command/response codes and FSM states for the Mac keyboard protocol block.
package mac_kbd_pkg;

    localparam logic [7:0] CMD_INQUIRY = 8'h10;
    localparam logic [7:0] CMD_INSTANT = 8'h14;
    localparam logic [7:0] CMD_MODEL   = 8'h16;
    localparam logic [7:0] CMD_TEST    = 8'h36;

    localparam logic [7:0] RSP_NULL    = 8'h7B;
    localparam logic [7:0] RSP_ACK     = 8'h7D;
    localparam logic [7:0] RSP_MODEL   = 8'h0B;

    localparam int TIMER_W = 21;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        WAIT_KEY,
        RESPOND
    } state_t;

endpackage

// File: rtl/mac_kbd_fifo.sv
// Key-byte FIFO: push on any clk, pop/flush qualified by the caller.
// DEPTH must be a power of two, at least 2.
module mac_kbd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mac_keyboard.sv
// Mac keyboard protocol responder: buffers MCU key bytes and answers Mac commands.
// Define MAC_KBD_INQUIRY_TIMEOUT_EN to enable the Inquiry (WAIT_KEY) Null timeout.
module mac_keyboard
    import mac_kbd_pkg::*;
#(
    parameter int TIMEOUT    = 2000000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       kbd_strobe,
    input  logic [7:0] kbd_data,
    input  logic [7:0] data_out,
    input  logic       strobe_out,
    output logic [7:0] data_in,
    output logic       strobe_in
);
    state_t     state;
    logic [7:0] cmd;
    logic [7:0] head;
    logic       full;
    logic       empty;
    logic       pop;
    logic       flush;
    logic       expired;

    mac_kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (kbd_strobe),
        .pop   (pop),
        .flush (flush),
        .din   (kbd_data),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pop   = 1'b0;
        flush = 1'b0;
        if (en) begin
            case (state)
                DECODE: begin
                    if ((cmd == CMD_INQUIRY || cmd == CMD_INSTANT) && !empty) pop = 1'b1;
                    if (cmd == CMD_MODEL) flush = 1'b1;
                end
                WAIT_KEY: pop = !empty;
                default: ;
            endcase
        end
    end

`ifdef MAC_KBD_INQUIRY_TIMEOUT_EN
    logic [TIMER_W-1:0] timer;

    assign expired = (timer == TIMER_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else if (en) begin
            if (state == WAIT_KEY && empty && !expired) timer <= timer + 1'b1;
            else                                        timer <= '0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;
    assign expired = 1'b0;
`endif

    // strobe_in rises when a response is chosen and drops on the next en edge,
    // so it covers exactly one en=1 clk regardless of the en phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= '0;
            data_in   <= '0;
            strobe_in <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (strobe_out) begin
                        cmd   <= data_out;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    state     <= RESPOND;
                    strobe_in <= 1'b1;
                    case (cmd)
                        CMD_INQUIRY: begin
                            if (!empty) begin
                                data_in <= head;
                            end else begin
                                state     <= WAIT_KEY;
                                strobe_in <= 1'b0;
                            end
                        end
                        CMD_INSTANT: data_in <= empty ? RSP_NULL : head;
                        CMD_MODEL:   data_in <= RSP_MODEL;
                        CMD_TEST:    data_in <= RSP_ACK;
                        default:     data_in <= RSP_NULL;
                    endcase
                end
                WAIT_KEY: begin
                    // a key available on the same edge as expiry wins
                    if (!empty) begin
                        data_in   <= head;
                        strobe_in <= 1'b1;
                        state     <= RESPOND;
                    end else if (expired) begin
                        data_in   <= RSP_NULL;
                        strobe_in <= 1'b1;
                        state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    strobe_in <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_keyboard.sv
// Directed plus randomized bench for mac_keyboard against a queue-based protocol model.
module tb_mac_keyboard;
    import mac_kbd_pkg::*;

    localparam int TO    = 100;
    localparam int DEPTH = 4;

    logic       clk        = 1'b0;
    logic       reset      = 1'b1;
    logic       en         = 1'b0;
    logic       kbd_strobe = 1'b0;
    logic [7:0] kbd_data   = 8'h00;
    logic [7:0] data_out   = 8'h00;
    logic       strobe_out = 1'b0;
    logic [7:0] data_in;
    logic       strobe_in;

    int tests = 0;
    int fails = 0;

    mac_keyboard #(.TIMEOUT(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .kbd_strobe (kbd_strobe),
        .kbd_data   (kbd_data),
        .data_out   (data_out),
        .strobe_out (strobe_out),
        .data_in    (data_in),
        .strobe_in  (strobe_in)
    );

    always #5 clk = ~clk;
    always @(negedge clk) en <= ~en;

    // en-edge index and every strobe_in pulse the Mac side would see
    int         en_cnt = 0;
    logic [7:0] rsp_q[$];
    int         rsp_idx_q[$];
    always @(posedge clk) begin
        if (en) begin
            if (strobe_in) begin
                rsp_q.push_back(data_in);
                rsp_idx_q.push_back(en_cnt);
            end
            en_cnt <= en_cnt + 1;
        end
    end

    logic [7:0] mq[$];

    function automatic logic [7:0] model_imm(logic [7:0] c);
        case (c)
            CMD_INQUIRY, CMD_INSTANT: return (mq.size() > 0) ? mq.pop_front() : RSP_NULL;
            CMD_MODEL: begin
                mq.delete();
                return RSP_MODEL;
            end
            CMD_TEST: return RSP_ACK;
            default:  return RSP_NULL;
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en();
        @(posedge clk);
        while (!en) @(posedge clk);
    endtask

    task automatic push_key(logic [7:0] b, output int j);
        wait_en();
        #1;
        j          = en_cnt - 1;
        kbd_data   = b;
        kbd_strobe = 1'b1;
        @(posedge clk);
        #1;
        kbd_strobe = 1'b0;
        if (mq.size() < DEPTH) mq.push_back(b);
    endtask

    task automatic send_cmd(logic [7:0] c, int len, output int idx);
        wait_en();
        #1;
        data_out   = c;
        strobe_out = 1'b1;
        wait_en();
        #1;
        idx = en_cnt - 1;
        repeat (len - 1) begin
            wait_en();
            #1;
        end
        strobe_out = 1'b0;
    endtask

    task automatic get_resp(string tag, logic [7:0] exp, int exp_idx, int bound);
        int k = 0;
        logic [7:0] d;
        int ri;
        while (rsp_q.size() == 0 && k < bound) begin
            wait_en();
            #1;
            k++;
        end
        tests++;
        assert (rsp_q.size() > 0) else begin
            fails++;
            $error("FAIL %s: got no response expected 0x%0h", tag, exp);
        end
        if (rsp_q.size() > 0) begin
            d  = rsp_q.pop_front();
            ri = rsp_idx_q.pop_front();
            chk({tag, " data"}, d, exp);
            if (exp_idx >= 0) chk({tag, " latency"}, ri, exp_idx);
        end
    endtask

    task automatic expect_none(int n, string tag);
        repeat (n) wait_en();
        #1;
        chk({tag, " no_rsp"}, rsp_q.size(), 0);
    endtask

    task automatic imm(logic [7:0] c, string tag);
        int idx;
        logic [7:0] e;
        send_cmd(c, 1, idx);
        e = model_imm(c);
        get_resp(tag, e, idx + 2, 20);
    endtask

    initial begin
        int idx, j;
        logic [7:0] k8, c;

        repeat (4) @(posedge clk);
        #1;
        chk("reset data_in", data_in, 8'h00);
        chk("reset strobe_in", strobe_in, 1'b0);
        reset = 1'b0;

        // Test -> ACK two en cycles later, then held
        imm(CMD_TEST, "test_ack");
        repeat (6) @(posedge clk);
        #1;
        chk("hold data_in", data_in, RSP_ACK);
        chk("hold strobe_in", strobe_in, 1'b0);
        imm(8'h55, "unknown_cmd");

        push_key(8'h0C, j);
        push_key(8'h8C, j);
        imm(CMD_INSTANT, "instant1");
        imm(CMD_INSTANT, "instant2");
        imm(CMD_INSTANT, "instant_empty");

        // overflow then Model flush
        for (int i = 0; i < 5; i++) push_key(8'($urandom_range(0, 255)), j);
        chk("model_fill", mq.size(), DEPTH);
        imm(CMD_MODEL, "model");
        imm(CMD_INSTANT, "after_flush");

        // overflow then drain
        for (int i = 0; i < 5; i++) push_key(8'($urandom_range(0, 255)), j);
        for (int i = 0; i < 5; i++) imm(CMD_INSTANT, "drain");

        push_key(8'h2A, j);
        imm(CMD_INQUIRY, "inquiry_ready");

`ifdef MAC_KBD_INQUIRY_TIMEOUT_EN
        send_cmd(CMD_INQUIRY, 1, idx);
        get_resp("inq_timeout", RSP_NULL, idx + TO + 2, TO + 20);
        send_cmd(CMD_INQUIRY, 1, idx);
        repeat (49) wait_en();
        push_key(8'h33, j);
        void'(mq.pop_front());
        get_resp("inq_key50", 8'h33, j + 2, 20);
        send_cmd(CMD_INQUIRY, 1, idx);
        repeat (TO - 1) wait_en();
        push_key(8'h44, j);
        void'(mq.pop_front());
        chk("prio_edge", j, idx + TO);
        get_resp("key_over_timeout", 8'h44, j + 2, 20);
        expect_none(TO + 10, "prio_single");
`else
        send_cmd(CMD_INQUIRY, 1, idx);
        expect_none(3 * TO, "inq_wait_forever");
        push_key(8'h33, j);
        void'(mq.pop_front());
        get_resp("inq_late_key", 8'h33, j + 2, 20);
`endif

        // reset in WAIT_KEY
        send_cmd(CMD_INQUIRY, 1, idx);
        repeat (10) wait_en();
        #1;
        reset      = 1'b1;
        kbd_data   = 8'h5A;
        kbd_strobe = 1'b1;
        strobe_out = 1'b1;
        data_out   = CMD_TEST;
        repeat (4) @(posedge clk);
        #1;
        kbd_strobe = 1'b0;
        strobe_out = 1'b0;
        chk("rst_mid data_in", data_in, 8'h00);
        chk("rst_mid strobe_in", strobe_in, 1'b0);
        reset = 1'b0;
        mq.delete();
        expect_none(TO + 20, "after_reset");
        imm(CMD_INSTANT, "rst_fifo_empty");
        imm(CMD_TEST, "rst_then_test");

        // strobe_out held across DECODE/RESPOND is ignored
        send_cmd(CMD_TEST, 3, idx);
        get_resp("long_strobe", RSP_ACK, idx + 2, 20);
        expect_none(10, "long_strobe_single");
        // strobe_out during WAIT_KEY is ignored
        send_cmd(CMD_INQUIRY, 1, idx);
        repeat (3) wait_en();
        send_cmd(CMD_INQUIRY, 1, idx);
        push_key(8'h66, j);
        void'(mq.pop_front());
        get_resp("waitkey_ignore", 8'h66, j + 2, 20);
        expect_none(20, "waitkey_single");

        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 3)) push_key(8'($urandom_range(0, 255)), j);
            case ($urandom_range(0, 4))
                0: c = CMD_INQUIRY;
                1: c = CMD_INSTANT;
                2: c = CMD_MODEL;
                3: c = CMD_TEST;
                default: begin
                    c = 8'($urandom_range(0, 255));
                    while (c == CMD_INQUIRY || c == CMD_INSTANT || c == CMD_MODEL || c == CMD_TEST)
                        c = 8'($urandom_range(0, 255));
                end
            endcase
            if (c == CMD_INQUIRY && mq.size() == 0) begin
                send_cmd(c, 1, idx);
                repeat ($urandom_range(1, 30)) wait_en();
                k8 = 8'($urandom_range(0, 255));
                push_key(k8, j);
                void'(mq.pop_front());
                get_resp("rand_wait", k8, j + 2, 20);
            end else begin
                imm(c, "rand_imm");
            end
        end
        expect_none(10, "final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mac_keyboard.md
MAC_KEYBOARD -- requirements
Module: mac_keyboard

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 2000000, giving the Inquiry timeout in en cycles (0.25 s at 8 MHz).
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, giving the key FIFO depth in bytes (power of 2).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock (16 MHz); all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: 8 MHz clock enable that qualifies all protocol and timer logic.
REQ-006 SHALL have port kbd_strobe, input, 1 bit: one-clk pulse from the external MCU marking a key byte; sampled every clk, not gated by en.
REQ-007 SHALL have port kbd_data, input, 8 bits: Mac key-transition byte, with bit7=1 meaning key up; prefix bytes (0x79) are passed through as ordinary bytes.
REQ-008 SHALL have port data_out, input, 8 bits: command byte received from the Mac.
REQ-009 SHALL have port strobe_out, input, 1 bit: one-en-cycle pulse marking data_out as valid.
REQ-010 SHALL have port data_in, output, 8 bits: response byte sent to the Mac.
REQ-011 SHALL have port strobe_in, output, 1 bit: pulse high for exactly one clk on which en=1, marking data_in as valid.

Function
REQ-012 SHALL queue kbd_data in a FIFO on kbd_strobe; when the FIFO is full, the new byte is dropped and contents are unchanged.
REQ-013 SHALL apply a simultaneous push and pop in the same cycle; a push into an empty FIFO is poppable on the next en cycle.
REQ-014 SHALL latch data_out on strobe_out only in state IDLE; a strobe_out in any other state is ignored.
REQ-015 SHALL implement states IDLE, DECODE, WAIT_KEY and RESPOND.
REQ-016 SHALL, on command 0x10 (Inquiry), pop and respond with the FIFO head if non-empty; otherwise go to WAIT_KEY.
REQ-017 SHALL, in WAIT_KEY, respond with the first key pushed, or with 0x7B (Null) when the timer reaches TIMEOUT.
REQ-018 SHALL, on command 0x14 (Instant), respond immediately with the popped head, or with 0x7B if the FIFO is empty.
REQ-019 SHALL, on command 0x16 (Model), flush the FIFO and respond with 0x0B.
REQ-020 SHALL, on command 0x36 (Test), respond with 0x7D (ACK).
REQ-021 SHALL respond to any other command byte with 0x7B.
REQ-022 SHALL pulse strobe_in exactly 2 en cycles after strobe_out for immediate responses (DECODE then RESPOND), and return to IDLE on the same edge.
REQ-023 SHALL hold data_in stable from the strobe_in pulse until the next response.
REQ-024 SHALL use a 21-bit timer that increments only in WAIT_KEY on en and clears on leaving WAIT_KEY.
REQ-025 SHALL give a key arrival priority over timeout when both occur in the same en cycle.

Reset
REQ-026 SHALL, on reset=1 at any clk edge including mid-transaction, force: state IDLE, FIFO empty, timer 0, data_in 0x00, strobe_in 0.
REQ-027 SHALL ignore kbd_strobe and strobe_out while reset is high.

Configuration
REQ-028 SHALL use macro MAC_KBD_INQUIRY_TIMEOUT_EN: when defined, the WAIT_KEY timeout (REQ-017) is active.
REQ-029 SHALL, when MAC_KBD_INQUIRY_TIMEOUT_EN is undefined, have no timer: WAIT_KEY waits indefinitely for a key or reset, and TIMEOUT is unused.

Structure
REQ-030 SHALL place command codes (0x10, 0x14, 0x16, 0x36), response codes (0x7B, 0x7D, 0x0B) and the state enum in shared package mac_kbd_pkg.
REQ-031 SHALL implement the key FIFO as one sub-module, mac_kbd_fifo (push, pop, full, empty, head).

Verification
REQ-032 SHALL verify: strobe_out with 0x36 -> strobe_in 2 en cycles later, data_in=0x7D.
REQ-033 SHALL verify: push 0x0C and 0x8C, then Instant twice -> 0x0C then 0x8C; a third Instant -> 0x7B.
REQ-034 SHALL verify: TIMEOUT=100, macro defined, Inquiry with empty FIFO -> data_in=0x7B at 100 en cycles; a key pushed at cycle 50 -> that key at cycle 51.
REQ-035 SHALL verify: 5 keys pushed at depth 4, Model -> 0x0B, and a following Instant -> 0x7B (flushed); before Model, Instants return the first 4 keys.
REQ-036 SHALL verify: reset asserted during WAIT_KEY -> IDLE, no strobe_in, and a following Test -> 0x7D.
REQ-037 SHALL verify: strobe_out 0x10 while in RESPOND/WAIT_KEY is ignored, giving exactly one response.
